// File: rtl/fpga_board_ctrl.sv
// Board control sequencer: turns debounced button press flags into
// core reset, run/halt and single-step actions with pending-event arbitration.
module fpga_board_ctrl #(
    parameter int unsigned RST_CYCLES   = 1024,
    parameter int unsigned STEP_TIMEOUT = 4096,
    parameter bit          RUN_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] btn_rflag,
    input  logic       step_ack,
    output logic       core_rstn,
    output logic       core_run,
    output logic       step_pulse,
    output logic       busy,
    output logic       step_timeout,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_STEP,
        S_WAIT
    } state_t;

    // Counters compare against the last cycle so the next edge leaves the state
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STEP_LAST = 16'(STEP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  pend_clr;
    logic        core_rstn_q, core_rstn_d;
    logic        core_run_q, core_run_d;
    logic        step_pulse_q, step_pulse_d;
    logic        busy_q, busy_d;
    logic        step_timeout_q, step_timeout_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // State and registered outputs; board reset holds the core in reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_RESET;
            cnt_q          <= 16'd0;
            pend_q         <= 3'b000;
            core_rstn_q    <= 1'b0;
            core_run_q     <= RUN_ON_RESET;
            step_pulse_q   <= 1'b0;
            busy_q         <= 1'b1;
            step_timeout_q <= 1'b0;
            drop_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            core_rstn_q    <= core_rstn_d;
            core_run_q     <= core_run_d;
            step_pulse_q   <= step_pulse_d;
            busy_q         <= busy_d;
            step_timeout_q <= step_timeout_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Next state, fixed-priority grant from IDLE, and output precompute
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_clr       = 3'b000;
        core_run_d     = core_run_q;
        step_timeout_d = step_timeout_q;
        drop_cnt_d     = drop_cnt_q;
        case (state_q)
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (pend_q[0]) begin
                    pend_clr       = 3'b001;
                    state_d        = S_RESET;
                    cnt_d          = 16'd0;
                    core_run_d     = RUN_ON_RESET;
                    step_timeout_d = 1'b0;
                end else if (pend_q[1]) begin
                    pend_clr   = 3'b010;
                    core_run_d = ~core_run_q;
                end else if (pend_q[2]) begin
                    pend_clr = 3'b100;
                    if (core_run_q) begin
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (step_ack) begin
                    state_d = S_IDLE;
                end else if (cnt_q == STEP_LAST) begin
                    step_timeout_d = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = 16'd0;
            end
        endcase
        // A new press on the bit being granted survives the clear
        pend_d       = (pend_q & ~pend_clr) | btn_rflag;
        core_rstn_d  = (state_d != S_RESET);
        step_pulse_d = (state_d == S_STEP);
        busy_d       = (state_d != S_IDLE);
    end

    assign core_rstn    = core_rstn_q;
    assign core_run     = core_run_q;
    assign step_pulse   = step_pulse_q;
    assign busy         = busy_q;
    assign step_timeout = step_timeout_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/fpga_board_ctrl.md
# fpga_board_ctrl

Board-level control sequencer for the FPGA prototype. It takes the one-cycle press flags produced by the per-button debouncers and turns them into core control actions: a stretched core reset, run/halt toggling, and halted single-stepping. Simultaneous presses are arbitrated at fixed priority, and presses that arrive while an action is running are held pending rather than lost. It sits between the debouncer instances and the DUT's reset/run/step controls.

## Interface
- RST_CYCLES, default 1024: cycles core_rstn is held low per reset action, range 1..65535.
- STEP_TIMEOUT, default 4096: cycles to wait for step_ack after a step, range 1..65535.
- RUN_ON_RESET, default 1: core_run value after rstn or after a reset action.
- clk  input  1  system clock.
- rstn  input  1  synchronous, active-low reset.
- btn_rflag  input  3  one-cycle press flags from the debouncers: [0] reset, [1] run/halt, [2] step.
- step_ack  input  1  core reports single-step completion; level or pulse.
- core_rstn  output  1  active-low core reset.
- core_run  output  1  1 = core free-running, 0 = halted.
- step_pulse  output  1  one-cycle step request to the core.
- busy  output  1  FSM is not in IDLE.
- step_timeout  output  1  sticky; a step received no ack within STEP_TIMEOUT.
- drop_cnt  output  8  saturating count of step presses discarded while running.

## Operation
- pend[2:0] is the pending-event register.
  - Bit i sets on btn_rflag[i] and clears when event i is granted.
  - If a set and a clear hit the same bit in the same cycle, the set wins, so a second press is served later.
- Arbitration happens only in IDLE, with pend != 0. The lowest set index is granted: reset, then run/halt, then step. One grant per cycle.
- FSM states: RESET, IDLE, STEP, STEP_WAIT.
- RESET
  - core_rstn = 0.
  - A 16-bit counter counts to RST_CYCLES, then the FSM goes to IDLE.
  - On entry, core_run is loaded with RUN_ON_RESET and step_timeout is cleared.
- IDLE, grant 0: go to RESET and clear the counter.
- IDLE, grant 1: toggle core_run and stay in IDLE. No extra state.
- IDLE, grant 2, core_run = 1: drop the event. drop_cnt increments and saturates at 255.
- IDLE, grant 2, core_run = 0: go to STEP.
- STEP
  - step_pulse = 1 for exactly this cycle.
  - Clear the counter and go to STEP_WAIT.
- STEP_WAIT
  - step_ack = 1: go to IDLE.
  - Otherwise, when the counter reaches STEP_TIMEOUT: set step_timeout and go to IDLE.
  - If step_ack and the timeout coincide, the ack wins and step_timeout is not set.
- While in RESET, STEP or STEP_WAIT, new presses only set pend. They are served in IDLE afterwards, in priority order.
- A reset press is never dropped. It is handled after the current step sequence completes or times out.
- step_ack is ignored outside STEP_WAIT.

## Timing
- On rstn = 0:
  - FSM goes to RESET with counter = 0, so the core is held in reset after board reset.
  - pend = 0, core_rstn = 0, core_run = RUN_ON_RESET, step_pulse = 0, step_timeout = 0, drop_cnt = 0, busy = 1.
- All outputs are registered.
- Reset action:
  - A btn_rflag[0] pulse in cycle t, with the FSM in IDLE, gives pend[0] = 1 at t+1.
  - The grant happens in t+1; core_rstn = 0 from t+2 for exactly RST_CYCLES cycles.
  - core_rstn returns to 1 at t+2+RST_CYCLES.
- Toggle: a press at t with the FSM in IDLE flips core_run at t+2.
- Step: a press at t with the FSM halted gives step_pulse = 1 at t+2 only.
- Timeout: with no ack, step_timeout rises STEP_TIMEOUT+1 cycles after step_pulse.
- busy = (state != IDLE).
- rstn asserted mid-sequence aborts immediately to the reset state above. Pending events are discarded.

## Test plan
- Power-up: rstn low 2 cycles, RST_CYCLES = 8 -> core_rstn low exactly 8 cycles after rstn release; core_run = 1; drop_cnt = 0.
- Toggle then step:
  - pulse btn[1] -> core_run = 0 two cycles later.
  - pulse btn[2] -> one step_pulse.
  - ack 3 cycles later -> busy drops the cycle after the ack; step_timeout = 0.
- Simultaneous btn = 3'b111 while halted:
  - reset is served first; core_run = 1 after RESET.
  - toggle is served next -> core_run = 0.
  - step is served last -> exactly one step_pulse.
- Step while running:
  - 3 step presses with core_run = 1 -> no step_pulse; drop_cnt = 3.
  - 300 presses -> drop_cnt = 255.
- Timeout: STEP_TIMEOUT = 16, no ack -> step_timeout = 1 at step_pulse+17 and stays set; a later reset press clears it.
- Press during RESET: btn[1] pulse mid-RESET -> core_run toggles 1 cycle after core_rstn releases.
